// File: rtl/host_msix_capture_if.sv
// Host write stream and forwarded memory-port write, bundled for host_msix_capture.
// slave = capture block side, master = host/memory model side.
interface host_msix_capture_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_be;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be, mem_ready,
        input  wr_ready, mem_valid, mem_addr, mem_data, mem_be
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be, mem_ready,
        output wr_ready, mem_valid, mem_addr, mem_data, mem_be
    );
endinterface

// File: rtl/host_msix_capture.sv
// MSI-X message-window capture: per-vector pending bits and saturating hit counters, others forwarded.
// Optional macro HOST_MSIX_FWD_EN: qualified hits are also forwarded to the memory port.
module host_msix_capture #(
    parameter int unsigned NUM_VEC   = 8,
    parameter int unsigned CNT_W     = 8,
    parameter logic [63:0] MSIX_BASE = 64'h0000_0000_FEE0_0000,
    parameter logic [31:0] MSIX_DATA = 32'h1234_5678,
    localparam int unsigned VEC_W    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    host_msix_capture_if.slave   bus,
    input  logic                 clr_valid,
    input  logic [VEC_W-1:0]     clr_vec,
    input  logic [VEC_W-1:0]     rd_vec,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [NUM_VEC-1:0]   pend,
    output logic                 intr_any,
    output logic                 bad_msix
);

    localparam logic [63:0]      WIN_BYTES = 64'(4 * NUM_VEC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [63:0]        win_off;
    logic               in_win;
    logic               qual;
    logic               accept;
    logic               hit;
    logic               fwd_load;
    logic [VEC_W-1:0]   hit_vec;
    logic [NUM_VEC-1:0] hit_oh;
    logic [NUM_VEC-1:0] clr_oh;
    logic [NUM_VEC-1:0] pend_q;
    logic [CNT_W-1:0]   cnt [NUM_VEC];
    logic               mem_valid_q;
    logic [63:0]        mem_addr_q;
    logic [31:0]        mem_data_q;
    logic [3:0]         mem_be_q;
    logic               bad_q;

    // Window membership uses the unsigned offset so addresses below the base never alias in.
    assign win_off = bus.wr_addr - MSIX_BASE;
    assign in_win  = (bus.wr_addr >= MSIX_BASE) && (win_off < WIN_BYTES);
    assign qual    = (bus.wr_addr[1:0] == 2'b00) && (bus.wr_be == 4'hF) &&
                     (bus.wr_data == MSIX_DATA);
    assign hit_vec = win_off[VEC_W+1:2];

    assign accept  = bus.wr_valid && bus.wr_ready;
    assign hit     = accept && in_win && qual;

`ifdef HOST_MSIX_FWD_EN
    assign fwd_load = accept;
`else
    assign fwd_load = accept && !hit;
`endif

    always_comb begin
        hit_oh = '0;
        clr_oh = '0;
        for (int v = 0; v < NUM_VEC; v++) begin
            hit_oh[v] = hit && (hit_vec == VEC_W'(v));
            clr_oh[v] = clr_valid && (clr_vec == VEC_W'(v));
        end
    end

    // A hit on a vector being cleared in the same cycle restarts its count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            for (int v = 0; v < NUM_VEC; v++) begin
                cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VEC; v++) begin
                if (hit_oh[v]) begin
                    pend_q[v] <= 1'b1;
                    if (clr_oh[v]) begin
                        cnt[v] <= CNT_W'(1);
                    end else if (cnt[v] != CNT_MAX) begin
                        cnt[v] <= cnt[v] + 1'b1;
                    end
                end else if (clr_oh[v]) begin
                    pend_q[v] <= 1'b0;
                    cnt[v]    <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_be_q    <= '0;
        end else if (fwd_load) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= bus.wr_addr;
            mem_data_q  <= bus.wr_data;
            mem_be_q    <= bus.wr_be;
        end else if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= accept && in_win && !qual;
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int v = 0; v < NUM_VEC; v++) begin
            if (rd_vec == VEC_W'(v)) begin
                rd_cnt = cnt[v];
            end
        end
    end

    assign bus.wr_ready  = !mem_valid_q || bus.mem_ready;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_be    = mem_be_q;
    assign pend          = pend_q;
    assign intr_any      = |pend_q;
    assign bad_msix      = bad_q;

endmodule

// File: tb/tb_host_msix_capture.sv
// Self-checking bench for host_msix_capture: directed cases plus random traffic against a queue/array model.
module tb_host_msix_capture;
    localparam int          NV    = 8;
    localparam logic [63:0] BASE  = 64'h0000_0000_FEE0_0000;
    localparam logic [31:0] MDATA = 32'h1234_5678;
`ifdef HOST_MSIX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    host_msix_capture_if bus();
    logic       clr_valid;
    logic [2:0] clr_vec;
    logic [2:0] rd_vec;
    logic [7:0] rd_cnt;
    logic [7:0] pend;
    logic       intr_any;
    logic       bad_msix;

    host_msix_capture #(
        .NUM_VEC(NV), .CNT_W(8), .MSIX_BASE(BASE), .MSIX_DATA(MDATA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .clr_valid(clr_valid), .clr_vec(clr_vec), .rd_vec(rd_vec),
        .rd_cnt(rd_cnt), .pend(pend), .intr_any(intr_any), .bad_msix(bad_msix)
    );

    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } wr_t;

    bit [NV-1:0] m_pend;
    int          m_cnt [NV];
    wr_t         m_q [$];
    bit          m_bad;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: the forward register is an at-most-one-entry queue of pending memory writes.
    always @(posedge clk or negedge rst_n) begin : mdl
        bit acc, win, ok;
        int v;
        if (!rst_n) begin
            m_pend = '0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_q.delete();
            m_bad = 1'b0;
        end else begin
            acc = bus.wr_valid && (m_q.size() == 0 || bus.mem_ready);
            if (m_q.size() != 0 && bus.mem_ready) void'(m_q.pop_front());
            if (clr_valid && int'(clr_vec) < NV) begin
                m_pend[clr_vec] = 1'b0;
                m_cnt[clr_vec]  = 0;
            end
            m_bad = 1'b0;
            if (acc) begin
                win = (bus.wr_addr >= BASE) && (bus.wr_addr < BASE + 64'(4 * NV));
                ok  = win && (bus.wr_addr % 4 == 0) && (bus.wr_be == 4'hF) && (bus.wr_data == MDATA);
                if (ok) begin
                    v = int'((bus.wr_addr - BASE) / 4);
                    m_pend[v] = 1'b1;
                    if (m_cnt[v] < 255) m_cnt[v] = m_cnt[v] + 1;
                end
                if (win && !ok) m_bad = 1'b1;
                if (!ok || FWD) m_q.push_back('{a: bus.wr_addr, d: bus.wr_data, b: bus.wr_be});
            end
        end
    end

    always @(negedge clk) begin : cmp
        if (chk_en) begin
            check("pend", pend, m_pend);
            check("intr_any", intr_any, |m_pend);
            check("rd_cnt", rd_cnt, m_cnt[rd_vec]);
            check("bad_msix", bad_msix, m_bad);
            check("mem_valid", bus.mem_valid, m_q.size() != 0);
            check("wr_ready", bus.wr_ready, (m_q.size() == 0) || bus.mem_ready);
            if (m_q.size() != 0) begin
                check("mem_addr", bus.mem_addr, m_q[0].a);
                check("mem_data", bus.mem_data, m_q[0].d);
                check("mem_be", bus.mem_be, m_q[0].b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid = 1'b0;
        clr_valid = 1'b0;
    endtask

    // Holds the write until it is accepted; returns just after the accepting edge.
    task automatic put(input logic [63:0] a, input logic [31:0] d, input logic [3:0] b);
        bit r;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be = b;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            r = bus.wr_ready;
            step();
            if (r) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: write to %0h not accepted within 200 cycles", a);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_be = '0;
        bus.mem_ready = 1'b1;
        clr_valid = 1'b0;
        clr_vec = '0;
        rd_vec = '0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        step();
        step();
        check("rst_pend", pend, 8'h00);
        check("rst_wr_ready", bus.wr_ready, 1'b1);
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        rst_n = 1'b1;
        step();

        // Single hit to vector 2
        rd_vec = 3'd2;
        put(BASE + 64'd8, MDATA, 4'hF);
        idle();
        check("t1_pend", pend, 8'b0000_0100);
        check("t1_intr_any", intr_any, 1'b1);
        check("t1_rd_cnt", rd_cnt, 8'd1);
`ifdef HOST_MSIX_FWD_EN
        check("t1_mem_valid_fwd", bus.mem_valid, 1'b1);
        check("t1_mem_data_fwd", bus.mem_data, MDATA);
`else
        check("t1_mem_valid", bus.mem_valid, 1'b0);
`endif
        step();

`ifdef HOST_MSIX_FWD_EN
        rd_vec = 3'd1;
        put(BASE + 64'd4, MDATA, 4'hF);
        idle();
        check("fwd_pend1", pend[1], 1'b1);
        check("fwd_mem_valid", bus.mem_valid, 1'b1);
        check("fwd_mem_data", bus.mem_data, 32'h1234_5678);
        clr_valid = 1'b1;
        clr_vec = 3'd1;
        step();
        idle();
`endif

        // Saturation on vector 0, then clear
        rd_vec = 3'd0;
        bus.wr_addr = BASE;
        bus.wr_data = MDATA;
        bus.wr_be = 4'hF;
        bus.wr_valid = 1'b1;
        repeat (300) step();
        idle();
        check("t2_sat", rd_cnt, 8'd255);
        check("t2_pend0", pend[0], 1'b1);
        clr_valid = 1'b1;
        clr_vec = 3'd0;
        step();
        idle();
        check("t2_clr_pend0", pend[0], 1'b0);
        check("t2_clr_cnt", rd_cnt, 8'd0);
        check("t2_other_pend", pend, 8'b0000_0100);

        // Same-vector hit and clear: hit wins with count 1
        rd_vec = 3'd3;
        put(BASE + 64'd12, MDATA, 4'hF);
        put(BASE + 64'd12, MDATA, 4'hF);
        idle();
        check("t3_pre_cnt", rd_cnt, 8'd2);
        clr_valid = 1'b1;
        clr_vec = 3'd3;
        put(BASE + 64'd12, MDATA, 4'hF);
        idle();
        check("t3_pend3", pend[3], 1'b1);
        check("t3_cnt3", rd_cnt, 8'd1);
        clr_valid = 1'b1;
        clr_vec = 3'd2;
        put(BASE + 64'd12, MDATA, 4'hF);
        idle();
        check("t3_diff_pend2", pend[2], 1'b0);
        check("t3_diff_cnt3", rd_cnt, 8'd2);

        // Window write with wrong data
        put(BASE + 64'd4, 32'h0, 4'hF);
        idle();
        check("t4_bad", bad_msix, 1'b1);
        check("t4_mem_valid", bus.mem_valid, 1'b1);
        check("t4_mem_addr", bus.mem_addr, BASE + 64'd4);
        check("t4_pend1", pend[1], 1'b0);
        step();
        check("t4_bad_once", bad_msix, 1'b0);

        // Backpressure on forwarded stream
        bus.mem_ready = 1'b0;
        put(64'h1000_0000, 32'hA0, 4'h1);
        check("t5_ready_low", bus.wr_ready, 1'b0);
        bus.wr_addr = 64'h1000_0010;
        bus.wr_data = 32'hA1;
        bus.wr_be = 4'h3;
        repeat (3) begin
            step();
            check("t5_hold_addr", bus.mem_addr, 64'h1000_0000);
        end
        bus.mem_ready = 1'b1;
        put(64'h1000_0010, 32'hA1, 4'h3);
        put(64'h1000_0020, 32'hA2, 4'h7);
        put(64'h1000_0030, 32'hA3, 4'hF);
        idle();
        check("t5_last_addr", bus.mem_addr, 64'h1000_0030);
        step();
        check("t5_drained", bus.mem_valid, 1'b0);

        // Reset while a forwarded write is held
        bus.mem_ready = 1'b0;
        put(64'h2000_0000, 32'hBEEF, 4'hF);
        idle();
        rst_n = 1'b0;
        #1;
        check("t6_rst_mem_valid", bus.mem_valid, 1'b0);
        check("t6_rst_pend", pend, 8'h00);
        step();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        step();

        // Random traffic
        repeat (2000) begin
            int kind;
            int v;
            v = int'($urandom_range(0, NV - 1));
            kind = int'($urandom_range(0, 3));
            bus.wr_valid = ($urandom_range(0, 3) != 0);
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            clr_valid = ($urandom_range(0, 7) == 0);
            clr_vec = 3'($urandom_range(0, 7));
            rd_vec = 3'($urandom_range(0, 7));
            bus.wr_addr = BASE + 64'(4 * v);
            bus.wr_data = MDATA;
            bus.wr_be = 4'hF;
            if (kind == 2) begin
                case ($urandom_range(0, 2))
                    0: bus.wr_data = MDATA ^ 32'($urandom_range(1, 255));
                    1: bus.wr_be = 4'($urandom_range(0, 14));
                    default: bus.wr_addr = BASE + 64'(4 * v + int'($urandom_range(1, 3)));
                endcase
            end else if (kind == 3) begin
                bus.wr_data = $urandom;
                bus.wr_be = 4'($urandom_range(0, 15));
                case ($urandom_range(0, 2))
                    0: bus.wr_addr = BASE - 64'(4 + 4 * $urandom_range(0, 63));
                    1: bus.wr_addr = BASE + 64'(4 * NV + 4 * $urandom_range(0, 63));
                    default: bus.wr_addr = {$urandom, $urandom};
                endcase
            end
            step();
        end
        idle();
        bus.mem_ready = 1'b1;
        step();
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/host_msix_capture.md
# host_msix_capture

Synthesizable successor to the behavioural host-memory write path with single-interrupt flagging. Sits between the device's host-write stream and the host memory model. It decodes writes that land in a parametrised MSI-X message window into per-vector pending bits and saturating hit counters. All other writes pass to the memory port through a one-entry pipeline register. It replaces the single hard-coded address/data interrupt check with NUM_VEC independently clearable vectors.

## Interface
- NUM_VEC, 8: number of MSI-X vectors, 1..32.
- CNT_W, 8: width of each per-vector hit counter.
- MSIX_BASE, 64'h0000_0000_FEE0_0000: byte address of vector 0; vector v sits at MSIX_BASE + 4*v.
- MSIX_DATA, 32'h1234_5678: message data that qualifies a hit.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  host write request valid
- wr_ready  out  1  host write accepted when wr_valid && wr_ready
- wr_addr  in  64  byte address, U64
- wr_data  in  32  dword data, U32
- wr_be  in  4  byte enables
- mem_valid  out  1  forwarded write valid
- mem_ready  in  1  memory-port accept
- mem_addr / mem_data / mem_be  out  64/32/4  forwarded write fields
- clr_valid  in  1  clear request, always accepted
- clr_vec  in  $clog2(NUM_VEC) (min 1)  vector to clear
- rd_vec  in  $clog2(NUM_VEC) (min 1)  counter read select
- rd_cnt  out  CNT_W  combinational counter value of rd_vec
- pend  out  NUM_VEC  per-vector pending bits
- intr_any  out  1  OR of pend
- bad_msix  out  1  one-cycle pulse: window write that fails qualification

## Operation
- Hit: accepted write with wr_addr in [MSIX_BASE, MSIX_BASE+4*NUM_VEC), wr_addr[1:0]==0, wr_be==4'hF, and wr_data==MSIX_DATA. The vector is (wr_addr-MSIX_BASE)>>2.
- Hit effects: pend[v] is set, and cnt[v] increments, saturating at 2^CNT_W-1. The hit is consumed and not forwarded.
- Window write that fails any qualifier: pulse bad_msix and forward it as a normal write.
- Non-window write: captured into the output register (mem_valid/addr/data/be).
- wr_ready = !mem_valid || mem_ready. The register loads on accept of a forwarded write. It clears when mem_ready && mem_valid and no new load occurs.
- Hits are accepted under the same wr_ready rule; acceptance ordering is never reordered.
- Clear: clr_valid zeroes pend[clr_vec] and cnt[clr_vec]. A clr_vec >= NUM_VEC is ignored.
- Simultaneous hit and clear on the same vector: the hit wins. pend=1 and cnt=1.
- Hit and clear on different vectors: both take effect.
- Reset: pend=0, all cnt=0, mem_valid=0, bad_msix=0. mem_addr/data/be reset to 0. intr_any=0 and wr_ready=1 follow from this.
- Reset mid-transfer drops any held forwarded write.

## Timing
- Hit accepted in cycle N: pend/intr_any/rd_cnt reflect it at N+1.
- Forwarded write accepted in cycle N: mem_valid=1 at N+1, held stable until mem_ready.
- Full throughput of one write per cycle when mem_ready is held high.
- bad_msix is asserted in cycle N+1 for exactly one cycle.
- Clear in cycle N: pend[v]=0 at N+1.

## Configuration
- HOST_MSIX_FWD_EN defined: qualified hits also pass through the forward register to the memory port, in addition to setting pend/cnt. Host memory then holds the message dword.
- Not defined: hits are consumed internally and never appear on mem_*.

## Test plan
- Reset, then write addr=MSIX_BASE+8, data=32'h12345678, be=F -> pend=8'b0000_0100, intr_any=1, rd_cnt(rd_vec=2)=1, no mem_valid (macro off).
- 300 hits to vector 0 with CNT_W=8 -> rd_cnt=255; clr_vec=0 -> pend[0]=0, rd_cnt=0 next cycle.
- Hit to vector 3 and clr_vec=3 in the same cycle -> pend[3]=1, cnt[3]=1.
- Write to MSIX_BASE+4 with data=32'h0 -> bad_msix pulse, mem_valid=1 with mem_addr=MSIX_BASE+4, pend unchanged.
- Stream of 4 non-window writes with mem_ready low for 3 cycles -> wr_ready=0 after the first, mem_addr held, all 4 delivered in order once ready.
- With HOST_MSIX_FWD_EN: hit to vector 1 -> pend[1]=1 and mem_valid=1 with mem_data=32'h12345678.
